// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master word-bus arbiter: FSM encoding,
// master indices and the default lock-chain length.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MST_0 = 1'b0;
    localparam logic MST_1 = 1'b1;

    localparam int MAX_HOLD_DEF = 4;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: the pointer only matters when both masters ask.
module rr_pick2
    import bus_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic winner_o,
    output logic any_req_o
);

    assign any_req_o = req0_i | req1_i;
    assign winner_o  = (req0_i & req1_i) ? ptr_i : (req1_i ? MST_1 : MST_0);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for a single-word peripheral bus with round-robin
// priority and bounded lock chaining.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic        m0_lock_i,
    input  logic [29:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m1_req_i,
    input  logic        m1_lock_i,
    input  logic [29:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic [31:0] m0_rdata_o,
    output logic [31:0] m1_rdata_o,
    output logic [29:0] s_addr_o,
    output logic [31:0] s_datai_o,
    output logic        s_we_o,
    input  logic [31:0] s_datao_i
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [29:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;

    logic        win, any_req;
    logic        src;
    logic [29:0] src_addr;
    logic        src_we;
    logic [31:0] src_wdata;
    logic        own_req, own_lock;
    logic        xfer_active;

    rr_pick2 u_pick (
        .req0_i    (m0_req_i),
        .req1_i    (m1_req_i),
        .ptr_i     (ptr_q),
        .winner_o  (win),
        .any_req_o (any_req)
    );

    // Fresh grants latch the winner's inputs; chained transfers re-latch the owner's.
    assign src       = (state_q == ST_IDLE) ? win : owner_q;
    assign src_addr  = src ? m1_addr_i  : m0_addr_i;
    assign src_we    = src ? m1_we_i    : m0_we_i;
    assign src_wdata = src ? m1_wdata_i : m0_wdata_i;
    assign own_req   = owner_q ? m1_req_i  : m0_req_i;
    assign own_lock  = owner_q ? m1_lock_i : m0_lock_i;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_XFER;
                    owner_d = win;
                    ptr_d   = ~win;
                    hold_d  = '0;
                    addr_d  = src_addr;
                    we_d    = src_we;
                    wdata_d = src_wdata;
                end
            end
            ST_XFER: begin
                state_d = ST_DONE;
                if (!we_q) begin
                    if (owner_q == MST_1) rdata1_d = s_datao_i;
                    else                  rdata0_d = s_datao_i;
                end
            end
            ST_DONE: begin
                if (own_lock && own_req && (hold_q < HOLD_LAST)) begin
                    state_d = ST_XFER;
                    hold_d  = hold_q + HOLD_W'(1);
                    addr_d  = src_addr;
                    we_d    = src_we;
                    wdata_d = src_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= MST_0;
            ptr_q    <= MST_0;
            hold_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Bus drive and acks decode straight from state so reset kills them at once.
    assign xfer_active = (state_q == ST_XFER);
    assign s_we_o      = xfer_active & we_q;
    assign s_addr_o    = xfer_active ? addr_q  : '0;
    assign s_datai_o   = xfer_active ? wdata_q : '0;
    assign m0_ack_o    = (state_q == ST_DONE) && (owner_q == MST_0);
    assign m1_ack_o    = (state_q == ST_DONE) && (owner_q == MST_1);
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum number of back-to-back transfers one master may chain while holding lock.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 m0_req / m1_req  input  1 each  master requests one word transfer; held high until that master's ack.
REQ-005 m0_lock / m1_lock  input  1 each  master asks to keep the bus for its next request.
REQ-006 m0_addr / m1_addr  input  30 each  word address [31:2].
REQ-007 m0_we / m1_we  input  1 each  1 = write, 0 = read.
REQ-008 m0_wdata / m1_wdata  input  32 each  write data.
REQ-009 m0_ack / m1_ack  output  1 each  one-cycle pulse; transfer complete.
REQ-010 m0_rdata / m1_rdata  output  32 each  registered read data, valid from the ack cycle until that master's next ack.
REQ-011 s_addr  output  30  peripheral-bus word address [31:2].
REQ-012 s_dataI  output  32  peripheral-bus write data.
REQ-013 s_we  output  1  peripheral-bus write enable.
REQ-014 s_dataO  input  32  peripheral-bus combinational read data.

Function
REQ-015 The FSM shall have exactly three states: IDLE, XFER and DONE.
REQ-016 IDLE: if any req is high, pick the winner per REQ-020, latch its addr/we/wdata into internal registers, set owner, go to XFER; otherwise stay in IDLE.
REQ-017 XFER: drive s_addr/s_dataI/s_we from the latched registers for exactly one cycle; at the clock edge ending XFER, capture s_dataO into the owner's rdata register (reads only); go to DONE.
REQ-018 DONE: assert the owner's ack for this cycle only; go to IDLE unless REQ-021 applies.
REQ-019 Outside XFER, s_addr = 0, s_dataI = 0 and s_we = 0; s_we is never high for more than one consecutive cycle per transfer.
REQ-020 Round-robin arbitration: the priority pointer starts at m0; after each grant the pointer moves to the other master; with a single requester, that requester wins regardless of the pointer.
REQ-021 Lock chaining: in DONE, if the owner's lock and req are both high and hold_cnt < MAX_HOLD-1, re-latch the owner's inputs, increment hold_cnt, go directly to XFER, and do not move the pointer.
REQ-022 hold_cnt clears on every non-chained grant; when hold_cnt reaches MAX_HOLD-1, the bus returns to IDLE and normal arbitration, so a waiting master is granted next.
REQ-023 Latency: a request seen in IDLE in cycle N gives the slave access in cycle N+1 and ack in cycle N+2; a chained transfer gives ack every 2 cycles.
REQ-024 Masters whose req is high while the other master owns the bus receive no ack and no rdata change.
REQ-025 A req that drops before its ack is ignored once latched; the transfer completes and the ack is still issued.
REQ-026 Simultaneous req from both masters in IDLE resolves strictly by the pointer; at most one ack is high in any cycle.

Reset
REQ-027 Asserting reset (low) at any time shall force IDLE, owner = m0, pointer = m0, hold_cnt = 0, both acks = 0, both rdata = 0, and s_addr/s_dataI/s_we = 0.
REQ-028 A transfer in XFER when reset asserts is abandoned with no ack; s_we drops immediately.

Structure
REQ-029 The shared package holds the state encoding (IDLE/XFER/DONE), the master-index constants and the MAX_HOLD default.
REQ-030 Round-robin selection lives in one sub-module, rr_pick2 (inputs: two reqs, pointer; output: winner index, any_req).

Verification
REQ-031 Single read: m0 reads 0x00007f04, s_dataO = 0x0000_1234 -> s_addr valid in cycle N+1, m0_ack and m0_rdata = 0x1234 in cycle N+2.
REQ-032 Single write: m1 writes 0xDEADBEEF to 0x00007f10 -> s_we high for exactly one cycle with s_dataI = 0xDEADBEEF; m1_ack follows one cycle later.
REQ-033 Contention: both reqs held continuously from reset, no lock -> acks alternate m0, m1, m0, m1.
REQ-034 Lock with MAX_HOLD = 4: m0 locked and requesting, m1 requesting -> four consecutive m0 acks, then an m1 ack.
REQ-035 Reset mid-XFER during a write -> s_we drops asynchronously, no ack occurs, and the next request after release completes normally.
REQ-036 Idle bus: no reqs for 10 cycles -> s_we, s_addr, s_dataI and both acks stay 0.
